// File: rtl/rr_arb4_enc.sv
// rr_arb4_enc: four-way round-robin arbiter with a registered one-hot grant
// and its 2-bit encoded index (grant bit i <-> index i).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req[3:0]   request vector, bit i = requester i
//   done       release strobe from the current owner (ignored while idle)
//   gnt[3:0]   registered one-hot grant, zero when idle
//   gnt_id     encoded index of gnt, 2'b00 when idle
//   gnt_valid  high while a grant is active (always |gnt)
//   timeout    one-cycle pulse when a grant was forcibly released
//
// Handshake: a grant is held while req[gnt_id]=1 and done=0. It is released
// on done=1, on the owner dropping its request, or on hold expiry. At release
// the next owner is picked in the same cycle, so grants hand over with no
// idle bubble when another requester is waiting.
//
// Optional feature: define ARB_TIMEOUT_EN to enable the MAX_HOLD hold
// limit. Without it a grant is held indefinitely and timeout is tied to 0.
// gnt_valid mirrors the FSM state (IDLE=0, GRANT=1) for observation.
module rr_arb4_enc #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arb4_enc: MAX_HOLD must be in 1..255");
  end

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state, state_n;
  logic [3:0] gnt_n;
  logic [1:0] gnt_id_n;
  logic [1:0] last, last_n;
  logic       release_now;
  logic       force_rel;
  logic       do_arb;
  logic [3:0] arb_req;
  logic [1:0] arb_ptr;
  logic [2:0] pick;
  logic       grant_load;

  // Search order p+1, p+2, p+3, p. Lowest priority is visited first so the
  // highest-priority set bit is the last one written.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;
  logic       timeout_q;

  // Forced release only when the owner would otherwise keep the slot; a
  // coinciding done is an ordinary release with no timeout pulse.
  assign force_rel = (state == GRANT) && (hold_cnt == HOLD_LAST) && !done && req[gnt_id];
  assign timeout   = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= force_rel;
      if (grant_load)
        hold_cnt <= 8'd0;
      else if (state == GRANT)
        hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign release_now = (state == GRANT) && (done || !req[gnt_id] || force_rel);
  assign do_arb      = (state == IDLE) || release_now;

  // On release the owner becomes the new pointer and is masked out, so it
  // cannot win again without passing through IDLE.
  assign arb_ptr    = release_now ? gnt_id : last;
  assign arb_req    = release_now ? (req & ~gnt) : req;
  assign pick       = rr_pick(arb_req, arb_ptr);
  assign grant_load = do_arb && pick[2];

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    gnt_id_n = gnt_id;
    last_n   = last;
    if (release_now) last_n = gnt_id;
    if (do_arb) begin
      if (pick[2]) begin
        state_n  = GRANT;
        gnt_n    = 4'b0001 << pick[1:0];
        gnt_id_n = pick[1:0];
      end else begin
        state_n  = IDLE;
        gnt_n    = 4'b0000;
        gnt_id_n = 2'b00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= 4'b0000;
      gnt_id <= 2'b00;
      last   <= 2'b11;
    end else begin
      state  <= state_n;
      gnt    <= gnt_n;
      gnt_id <= gnt_id_n;
      last   <= last_n;
    end
  end

  assign gnt_valid = |gnt;

endmodule

// File: doc/rr_arb4_enc.md
Name: rr_arb4_enc

Overview:
- Round-robin arbiter that shares one 4-to-2 encoded resource slot among four requesters.
- Produces a registered one-hot grant plus its 2-bit encoded index. The index uses the same mapping as the team's 4-to-2 encoder: grant bit i gives index i.
- Sits in front of the shared datapath. A grant is held until the owner releases it, withdraws, or (optionally) times out.

Parameters:
- MAX_HOLD, 8, maximum cycles a single grant may be held. Used only when ARB_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- req  input  4  request vector; bit i = requester i.
- done  input  1  release strobe from the current owner; valid only while gnt_valid=1.
- gnt  output  4  registered one-hot grant; all-zero when idle.
- gnt_id  output  2  encoded index of the granted requester.
- gnt_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. When rst=1 is sampled, the next edge sets:
  - state=IDLE, gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, timeout=0;
  - priority pointer last=2'b11, so requester 0 has highest priority first;
  - hold counter cleared.
- Reset applies mid-grant with no release handshake.
- Rotating priority: search order is last+1, last+2, last+3, last, all modulo 4. The first set req bit in that order wins.
- State IDLE:
  - req==0: stay in IDLE; outputs stay zero.
  - Any req bit set: winner registered. The next edge sets gnt/gnt_id/gnt_valid and moves to GRANT.
  - Latency is 1 cycle from req sampled to gnt visible.
- State GRANT:
  - Outputs hold steady while the owner keeps req[gnt_id]=1 and done=0.
  - Release condition: done=1, OR req[gnt_id]=0 (withdrawal), OR timeout (feature only).
  - On release: last <= gnt_id, then arbitrate in the same cycle over the current req with the owner's bit masked.
    - Another request pending: the next edge grants it directly. There is no idle bubble, gnt_valid stays 1, and the state stays GRANT.
    - No other request pending: the next edge clears the outputs and returns to IDLE. The releasing requester must wait one IDLE cycle before it can be re-granted.
- done sampled while gnt_valid=0 is ignored.
- Request changes from non-owners during GRANT have no effect until release.
- gnt is always one-hot or zero. gnt_id equals the encoded gnt whenever gnt_valid=1 and is 2'b00 when idle.
- gnt_valid = |gnt at all times.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on every new grant and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 with no done and the owner still requesting, the block forces a release, handled exactly like done=1.
  - timeout pulses 1 in the same cycle the new grant (or idle) becomes visible.
  - If done and timeout coincide, it is treated as a normal release and timeout stays 0.
- Not defined:
  - No counter logic.
  - A grant is held indefinitely.
  - timeout is tied to 0.

Test Plan:
- Reset: assert rst for 2 cycles with req=4'b1111, release it -> all outputs 0 during reset. The first grant, one cycle after release, is gnt=4'b0001, gnt_id=2'b00.
- Rotation: hold req=4'b1111 and pulse done once per grant -> grants 0,1,2,3,0 in order, back-to-back, gnt_valid never drops.
- Single requester: req=4'b0100, done after 3 cycles -> gnt=4'b0100, gnt_id=2'b10 for 3 cycles. Then idle one cycle, then re-granted if req[2] is still 1.
- Withdrawal: owner 1 drops req[1] while req[3]=1 -> next edge gnt=4'b1000, gnt_id=2'b11, last=2'b01.
- Mid-grant reset: while gnt=4'b0010, assert rst for 1 cycle -> next edge all outputs 0. After release the first grant starts from requester 0 again.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=4'b0011, owner 0 never asserts done -> gnt=4'b0001 for exactly 4 cycles, then gnt=4'b0010 with timeout=1 for one cycle.
